pwm_breath_bank: RTL

Parametrised multi-channel PWM LED driver: successor to the single-pair breathing driver, generalising it to N independent channels, each selectable between off, fully on, static duty and triangular "breathing" duty. A shared prescaler and PWM counter drive all channels. Duty and mode are latched only at PWM period boundaries, so outputs are glitch-free. Sits between board-level control logic (mode/duty registers) and the LED pins.

---
 rtl/pwm_breath_bank_if.sv | 16 +
 rtl/pwm_breath_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_bank_if.sv
// pwm_breath_bank_if: control/status bundle between board control logic and the
// PWM LED bank. The master drives per-channel mode/duty; the slave (the bank)
// returns LED drive, breathing peak pulses and the period-boundary pulse.
interface pwm_breath_bank_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned PWM_W = 8
);
    logic [2*N_CH-1:0]     mode;
    logic [PWM_W*N_CH-1:0] duty;
    logic [N_CH-1:0]       led;
    logic [N_CH-1:0]       peak;
    logic                  period_start;

    modport master (output mode, duty, input led, peak, period_start);
    modport slave  (input mode, duty, output led, peak, period_start);
endinterface

// File: rtl/pwm_breath_bank.sv
// pwm_breath_bank: N-channel PWM LED driver. A shared prescaler and PWM counter
// drive every channel; each channel is off, on, static duty or triangular
// breathing. Mode and duty are latched only at PWM period boundaries so the
// outputs never glitch mid-period.
// Optional feature macro: PWM_BREATH_GAMMA_EN -- when defined, breathing duty is
// squared ((bd*bd) >> PWM_W) for a perceptually linear fade; otherwise linear.
module pwm_breath_bank #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned PWM_W        = 8,
    parameter int unsigned PRESC        = 195,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned STEP         = 8
) (
    input logic              clk,
    input logic              rst,
    pwm_breath_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_STATIC  = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int unsigned      PRE_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned      STP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_W-1:0] MAX      = '1;
    localparam logic [PWM_W-1:0] STEP_N   = PWM_W'(STEP);
    localparam logic [PWM_W:0]   MAX_X    = {1'b0, MAX};
    localparam logic [PWM_W:0]   STEP_X   = (PWM_W + 1)'(STEP);
    localparam logic [PWM_W:0]   UP_LIM   = MAX_X - STEP_X;

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic [STP_W-1:0] step_cnt;
    logic             tick;
    logic             boundary;
    logic             step_ev;
    logic             period_start_q;

    mode_t            mode_in [N_CH];
    mode_t            mode_l  [N_CH];
    logic [PWM_W-1:0] duty_l  [N_CH];
    logic [PWM_W-1:0] bd      [N_CH];
    dir_t             dir     [N_CH];
    logic [PWM_W-1:0] ed      [N_CH];
`ifdef PWM_BREATH_GAMMA_EN
    logic [2*PWM_W-1:0] sq    [N_CH];
`endif
    logic [N_CH-1:0]  led_q;
    logic [N_CH-1:0]  peak_q;

    assign tick     = (pre_cnt == PRE_LAST);
    assign boundary = tick && (pwm_cnt == MAX);
    assign step_ev  = boundary && (step_cnt == STP_LAST);

    // Split the packed mode bus into per-channel enum values.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            mode_in[i] = mode_t'(bus.mode[2*i +: 2]);
        end
    end

    // Shared timebase: prescaler, PWM counter, step counter and boundary pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt        <= '0;
            pwm_cnt        <= '0;
            step_cnt       <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt        <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (boundary) begin
                step_cnt <= step_ev ? '0 : step_cnt + 1'b1;
            end
            period_start_q <= boundary;
        end
    end

    // Effective duty per channel from the latched mode.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ed[i] = '0;
`ifdef PWM_BREATH_GAMMA_EN
            sq[i] = {{PWM_W{1'b0}}, bd[i]} * {{PWM_W{1'b0}}, bd[i]};
`endif
            case (mode_l[i])
                MODE_STATIC:  ed[i] = duty_l[i];
`ifdef PWM_BREATH_GAMMA_EN
                MODE_BREATHE: ed[i] = sq[i][2*PWM_W-1:PWM_W];
`else
                MODE_BREATHE: ed[i] = bd[i];
`endif
                default:      ed[i] = '0;
            endcase
        end
    end

    // Per-channel latching, breathing triangle and registered LED compare.
    // The breathing update tests the incoming mode, not mode_l, so a boundary
    // that latches breathe also applies that boundary's step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                mode_l[i] <= MODE_OFF;
                duty_l[i] <= '0;
                bd[i]     <= '0;
                dir[i]    <= DIR_UP;
            end
            led_q  <= '0;
            peak_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                led_q[i]  <= (mode_l[i] == MODE_ON) ||
                             (((mode_l[i] == MODE_STATIC) || (mode_l[i] == MODE_BREATHE)) &&
                              (pwm_cnt < ed[i]));
                peak_q[i] <= 1'b0;
                if (boundary) begin
                    mode_l[i] <= mode_in[i];
                    duty_l[i] <= bus.duty[PWM_W*i +: PWM_W];
                    if (mode_in[i] != MODE_BREATHE) begin
                        bd[i]  <= '0;
                        dir[i] <= DIR_UP;
                    end else if (step_ev) begin
                        if (dir[i] == DIR_UP) begin
                            if ({1'b0, bd[i]} >= UP_LIM) begin
                                bd[i]     <= MAX;
                                dir[i]    <= DIR_DOWN;
                                peak_q[i] <= 1'b1;
                            end else begin
                                bd[i] <= bd[i] + STEP_N;
                            end
                        end else begin
                            if ({1'b0, bd[i]} <= STEP_X) begin
                                bd[i]  <= '0;
                                dir[i] <= DIR_UP;
                            end else begin
                                bd[i] <= bd[i] - STEP_N;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.led          = led_q;
    assign bus.peak         = peak_q;
    assign bus.period_start = period_start_q;
endmodule
